// File: rtl/div_ctrl_if.sv
// Handshake bundle between the execute stage, the divide controller and the
// iterative divider core.
//   req_*   : op issue from execute (valid/ready), flush kills the in-flight op
//   resp_*  : result towards writeback (valid/ready), busy stalls the pipeline
//   div_*   : operand/result exchange with the divider core
// The controller uses the slave modport; the surrounding pipeline/core model
// uses the master modport.
interface div_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic         req_word;
  logic [63:0]  req_rs1;
  logic [63:0]  req_rs2;
  logic [4:0]   req_rd;
  logic         flush;

  logic         resp_valid;
  logic         resp_ready;
  logic [63:0]  resp_data;
  logic [4:0]   resp_rd;
  logic         busy;

  logic         div_valid;
  logic         div_sign;
  logic         div_32;
  logic [63:0]  div_rs1;
  logic [63:0]  div_rs2;
  logic         div_ready;
  logic [127:0] div_result;

  modport slave (
    input  req_valid, req_op, req_word, req_rs1, req_rs2, req_rd, flush,
    input  resp_ready, div_ready, div_result,
    output req_ready, resp_valid, resp_data, resp_rd, busy,
    output div_valid, div_sign, div_32, div_rs1, div_rs2
  );

  modport master (
    output req_valid, req_op, req_word, req_rs1, req_rs2, req_rd, flush,
    output resp_ready, div_ready, div_result,
    input  req_ready, resp_valid, resp_data, resp_rd, busy,
    input  div_valid, div_sign, div_32, div_rs1, div_rs2
  );
endinterface

// File: rtl/div_ctrl.sv
// Divide/remainder sequencing controller. Accepts one DIV/DIVU/REM/REMU op
// (optionally W-variant), normalizes the operands, holds them to the divider
// core until it completes, then presents the selected, sign-extended result
// to writeback. Flush kills the op; an op killed mid-divide drains the core
// so it returns to its initial count before the next op.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (shared with the divider core)
//   bus  : div_ctrl_if.slave (request, response and divider-core signals)
//
// state | meaning
// IDLE  | ready for a new op (req_ready=1)
// RUN   | divider core working on the latched op
// DRAIN | op was flushed; keep div_valid up until the core finishes, drop result
// DONE  | result registered, waiting for writeback handshake
module div_ctrl (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  logic        load_req;
  logic        load_resp;

  logic        rem_q;
  logic        word_q;
  logic        sign_q;
  logic [63:0] rs1_q;
  logic [63:0] rs2_q;
  logic [4:0]  rd_q;
  logic [63:0] resp_data_q;
  logic [4:0]  resp_rd_q;

  logic        req_sign;
  logic [63:0] rs1_norm;
  logic [63:0] rs2_norm;
  logic [63:0] res_sel;
  logic [63:0] res_final;

  // DIV/REM are signed (op[0]=0). W ops feed the core a 64-bit operand that
  // is sign- or zero-extended from bit 31 depending on signedness.
  assign req_sign = ~bus.req_op[0];

  always_comb begin
    rs1_norm = bus.req_rs1;
    rs2_norm = bus.req_rs2;
    if (bus.req_word) begin
      rs1_norm = {{32{req_sign & bus.req_rs1[31]}}, bus.req_rs1[31:0]};
      rs2_norm = {{32{req_sign & bus.req_rs2[31]}}, bus.req_rs2[31:0]};
    end
  end

  // W results are always sign-extended from bit 31, unsigned variants too.
  assign res_sel   = rem_q ? bus.div_result[127:64] : bus.div_result[63:0];
  assign res_final = word_q ? {{32{res_sel[31]}}, res_sel[31:0]} : res_sel;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_req       = 1'b0;
    load_resp      = 1'b0;
    bus.req_ready  = 1'b0;
    bus.busy       = 1'b1;
    bus.div_valid  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.req_valid && !bus.flush) begin
          load_req  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        bus.div_valid = 1'b1;
        if (bus.flush) begin
          // A result arriving in the flush cycle is simply dropped; the core
          // is already back at its initial count, so no drain is needed.
          state_nxt = bus.div_ready ? IDLE : DRAIN;
        end else if (bus.div_ready) begin
          load_resp = 1'b1;
          state_nxt = DONE;
        end
      end
      DRAIN: begin
        bus.div_valid = 1'b1;
        if (bus.div_ready) state_nxt = IDLE;
      end
      DONE: begin
        bus.resp_valid = 1'b1;
        if (bus.flush || bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q       <= 1'b0;
      word_q      <= 1'b0;
      sign_q      <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      resp_data_q <= '0;
      resp_rd_q   <= '0;
    end else begin
      if (load_req) begin
        rem_q  <= bus.req_op[1];
        word_q <= bus.req_word;
        sign_q <= req_sign;
        rs1_q  <= rs1_norm;
        rs2_q  <= rs2_norm;
        rd_q   <= bus.req_rd;
      end
      if (load_resp) begin
        resp_data_q <= res_final;
        resp_rd_q   <= rd_q;
      end
    end
  end

  assign bus.div_sign  = sign_q;
  assign bus.div_32    = word_q;
  assign bus.div_rs1   = rs1_q;
  assign bus.div_rs2   = rs2_q;
  assign bus.resp_data = resp_data_q;
  assign bus.resp_rd   = resp_rd_q;

endmodule
